// File: rtl/csr_regfile_pkg.sv
// rtl/csr_regfile_pkg.sv - shared CSR numbers, field masks, ecodes and write helper
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] CRMD_RESET     = 32'h0000_0008;
  localparam logic [31:0] CRMD_WMASK     = 32'h0000_01ff;
  localparam logic [31:0] PRMD_WMASK     = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK     = 32'h0000_1bff;
  localparam logic [31:0] EENTRY_WMASK   = 32'hffff_ffc0;
  localparam logic [1:0]  ESTAT_SW_WMASK = 2'b11;
  localparam logic [31:0] TVAL_STOPPED   = 32'hffff_ffff;

  localparam logic [5:0]  ECODE_ADE = 6'h08;
  localparam logic [5:0]  ECODE_ALE = 6'h09;

  function automatic logic [31:0] mwrite(input logic [31:0] old_v,
                                         input logic [31:0] wval,
                                         input logic [31:0] wmask);
    return (old_v & ~wmask) | (wval & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TCFG/TVAL stable timer producing the IS[11] set pulse
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        tcfg_we_i,
  input  logic [31:0] tcfg_wmask_i,
  input  logic [31:0] tcfg_wval_i,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o,
  output logic        timer_set_o
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        set;

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    set    = 1'b0;
    if (tcfg_we_i) begin
      tcfg_d = mwrite(tcfg_q, tcfg_wval_i, tcfg_wmask_i);
    end
    // A fresh enable load beats any countdown in progress.
    if (tcfg_we_i && tcfg_d[0]) begin
      tval_d = {tcfg_d[31:2], 2'b00};
    end else if (tcfg_q[0] && (tval_q != TVAL_STOPPED)) begin
      if (tval_q == 32'h0) begin
        set    = 1'b1;
        tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : TVAL_STOPPED;
      end else begin
        tval_d = tval_q - 32'h1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tcfg_q <= 32'h0;
      tval_q <= 32'h0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tcfg_o      = tcfg_q;
  assign tval_o      = tval_q;
  assign timer_set_o = set;

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - architectural CSR file: masked writes, exception/ertn effects, reads
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wval,
  input  logic        wb_exc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badv,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc,
  output logic        has_int
);

  logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0] era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [1:0]  is_sw_q, is_sw_d;
  logic [7:0]  is_hw_q;
  logic        is_ipi_q, is_timer_q, is_timer_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [12:0] estat_is;
  logic [31:0] estat_val, tcfg, tval;
  logic        sw_we, tcfg_we, ticlr_hit, timer_set;

  // Exception and ertn commits own the edge; software writes only land on quiet edges.
  assign sw_we     = csr_we & ~wb_exc & ~ertn_flush;
  assign tcfg_we   = sw_we & (csr_wnum == CSR_TCFG);
  assign ticlr_hit = sw_we & (csr_wnum == CSR_TICLR) & csr_wmask[0] & csr_wval[0];
  assign estat_is  = {is_ipi_q, is_timer_q, 1'b0, is_hw_q, is_sw_q};
  assign estat_val = {1'b0, esubcode_q, ecode_q, 3'b000, estat_is};

  csr_timer u_timer (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .tcfg_we_i    (tcfg_we),
    .tcfg_wmask_i (csr_wmask),
    .tcfg_wval_i  (csr_wval),
    .tcfg_o       (tcfg),
    .tval_o       (tval),
    .timer_set_o  (timer_set)
  );

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    ecfg_d     = ecfg_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    tid_d      = tid_q;
    save_d     = save_q;
    is_sw_d    = is_sw_q;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    if (wb_exc) begin
      prmd_d      = {29'h0, crmd_q[2], crmd_q[1:0]};
      crmd_d[2:0] = 3'b000;
      ecode_d     = wb_ecode;
      esubcode_d  = wb_esubcode;
      era_d       = wb_pc;
      if ((wb_ecode == ECODE_ADE) || (wb_ecode == ECODE_ALE)) begin
        badv_d = wb_badv;
      end
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end else if (csr_we) begin
      case (csr_wnum)
        CSR_CRMD:   crmd_d   = mwrite(crmd_q, csr_wval, csr_wmask & CRMD_WMASK);
        CSR_PRMD:   prmd_d   = mwrite(prmd_q, csr_wval, csr_wmask & PRMD_WMASK);
        CSR_ECFG:   ecfg_d   = mwrite(ecfg_q, csr_wval, csr_wmask & ECFG_WMASK);
        CSR_ESTAT:  is_sw_d  = (is_sw_q & ~(csr_wmask[1:0] & ESTAT_SW_WMASK))
                             | (csr_wval[1:0] & csr_wmask[1:0] & ESTAT_SW_WMASK);
        CSR_ERA:    era_d    = mwrite(era_q, csr_wval, csr_wmask);
        CSR_BADV:   badv_d   = mwrite(badv_q, csr_wval, csr_wmask);
        CSR_EENTRY: eentry_d = mwrite(eentry_q, csr_wval, csr_wmask & EENTRY_WMASK);
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save_d[csr_wnum[1:0]] = mwrite(save_q[csr_wnum[1:0]], csr_wval, csr_wmask);
        CSR_TID:    tid_d    = mwrite(tid_q, csr_wval, csr_wmask);
        default:    ;
      endcase
    end
    is_timer_d = timer_set ? 1'b1 : (ticlr_hit ? 1'b0 : is_timer_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q     <= CRMD_RESET;
      prmd_q     <= 32'h0;
      ecfg_q     <= 32'h0;
      era_q      <= 32'h0;
      badv_q     <= 32'h0;
      eentry_q   <= 32'h0;
      tid_q      <= TID_RESET;
      save_q     <= '{default: 32'h0};
      is_sw_q    <= 2'b00;
      is_hw_q    <= 8'h00;
      is_ipi_q   <= 1'b0;
      is_timer_q <= 1'b0;
      ecode_q    <= 6'h00;
      esubcode_q <= 9'h000;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      tid_q      <= tid_d;
      save_q     <= save_d;
      is_sw_q    <= is_sw_d;
      is_hw_q    <= hw_int_in;
      is_ipi_q   <= ipi_int_in;
      is_timer_q <= is_timer_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
    end
  end

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat_val;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
        csr_rvalue = save_q[csr_rnum[1:0]];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = tval;
      default:    csr_rvalue = 32'h0;
    endcase
  end

  assign ex_entry = eentry_q;
  assign ertn_pc  = era_q;
  assign has_int  = (|(estat_is & ecfg_q[12:0])) & crmd_q[2];

  a_read_num_known: assert property (@(posedge clk) disable iff (!resetn)
                                     csr_re |-> !$isunknown(csr_rnum));

endmodule
